// File: rtl/wb_gpio_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_ctrl_if
// Purpose  : Wishbone classic slave bus bundle for wb_gpio_ctrl.
// Signals  : wb_adr_i[4:0]  byte address (bits [1:0] ignored by the slave)
//            wb_dat_i[31:0] write data      wb_dat_o[31:0] read data
//            wb_sel_i[3:0]  byte enables    wb_we_i/wb_cyc_i/wb_stb_i qualifiers
//            wb_ack_o       normal end      wb_err_o       error end
// Modports : master (drives the request), slave (drives the termination)
// Revision : 1.0  initial release
// ============================================================================
interface wb_gpio_ctrl_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wb_gpio_ctrl
// Purpose  : Wishbone-mapped GPIO block with per-pin direction, input
//            synchronizer (optional debounce filter), rise/fall edge
//            detection into a W1C status register and a masked level irq.
// Ports    : wb_clk, wb_rst_n (async, active-low)
//            wb       Wishbone slave bundle (wb_gpio_ctrl_if.slave)
//            gpio_i   pad inputs   gpio_o  pad outputs   gpio_oe  drive enables
//            irq      |(STATUS & MASK)
// Map      : 0x00 IN(RO) 0x04 OUT 0x08 DIR 0x0C RISE_EN 0x10 FALL_EN
//            0x14 STATUS(W1C) 0x18 MASK, 0x1C terminates with wb_err_o
// Config   : define WB_GPIO_CTRL_DEBOUNCE_EN to insert a per-pin filter that
//            needs DEBOUNCE consecutive differing clocks before it follows.
// Revision : 1.0  initial release
// ============================================================================
module wb_gpio_ctrl #(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4
) (
  input  wire logic             wb_clk,
  input  wire logic             wb_rst_n,
  wb_gpio_ctrl_if.slave         wb,
  input  wire logic [WIDTH-1:0] gpio_i,
  output logic      [WIDTH-1:0] gpio_o,
  output logic      [WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  logic [WIDTH-1:0] r_out, r_dir, r_rise_en, r_fall_en, r_status, r_mask;
  logic [WIDTH-1:0] r_sync1, r_sync2, r_filt_q;
  wire  [WIDTH-1:0] w_filt;
  logic             r_ack, r_err;
  logic [31:0]      r_dat;

  logic             w_req, w_bad, w_wr;
  logic [2:0]       w_idx;
  logic [WIDTH-1:0] w_wmask, w_wd, w_set, w_clr;
  logic [31:0]      w_rd;

  // The ack/err flag blocks a second request in the termination cycle, so a
  // master holding stb gets exactly one single-cycle ack per two clocks.
  assign w_req = wb.wb_cyc_i & wb.wb_stb_i & ~r_ack & ~r_err;
  assign w_idx = wb.wb_adr_i[4:2];
  assign w_bad = (w_idx == 3'd7);
  assign w_wr  = w_req & wb.wb_we_i & ~w_bad;
  assign w_wd  = wb.wb_dat_i[WIDTH-1:0];

  always_comb begin
    w_wmask = '0;
    for (int b = 0; b < WIDTH; b++) begin
      w_wmask[b] = wb.wb_sel_i[b / 8];
    end
  end

  function automatic logic [WIDTH-1:0] f_merge(input logic [WIDTH-1:0] old);
    return (old & ~w_wmask) | (w_wd & w_wmask);
  endfunction

  always_comb begin
    w_rd = '0;
    case (w_idx)
      3'd0:    w_rd[WIDTH-1:0] = w_filt;
      3'd1:    w_rd[WIDTH-1:0] = r_out;
      3'd2:    w_rd[WIDTH-1:0] = r_dir;
      3'd3:    w_rd[WIDTH-1:0] = r_rise_en;
      3'd4:    w_rd[WIDTH-1:0] = r_fall_en;
      3'd5:    w_rd[WIDTH-1:0] = r_status;
      3'd6:    w_rd[WIDTH-1:0] = r_mask;
      default: w_rd = '0;
    endcase
  end

  // Edge events compare the filtered value with its one-cycle-old copy.
  assign w_set = (w_filt & ~r_filt_q & r_rise_en) | (~w_filt & r_filt_q & r_fall_en);
  assign w_clr = (w_wr && w_idx == 3'd5) ? (w_wd & w_wmask) : '0;

  // Bus termination and read data
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_req & ~w_bad;
      r_err <= w_req & w_bad;
      r_dat <= (w_req && !w_bad) ? w_rd : '0;
    end
  end

  // Control registers, written at the edge that raises ack
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_out     <= '0;
      r_dir     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_mask    <= '0;
    end else if (w_wr) begin
      case (w_idx)
        3'd1:    r_out     <= f_merge(r_out);
        3'd2:    r_dir     <= f_merge(r_dir);
        3'd3:    r_rise_en <= f_merge(r_rise_en);
        3'd4:    r_fall_en <= f_merge(r_fall_en);
        3'd6:    r_mask    <= f_merge(r_mask);
        default: ;
      endcase
    end
  end

  // OR-ing the set term after the clear makes a new edge win over W1C.
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_status <= '0;
    end else begin
      r_status <= (r_status & ~w_clr) | w_set;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      r_sync1  <= '0;
      r_sync2  <= '0;
      r_filt_q <= '0;
    end else begin
      r_sync1  <= gpio_i;
      r_sync2  <= r_sync1;
      r_filt_q <= w_filt;
    end
  end

`ifdef WB_GPIO_CTRL_DEBOUNCE_EN
  genvar i;
  for (i = 0; i < WIDTH; i++) begin : g_debounce
    logic [7:0] r_cnt;
    logic       r_f;
    // Counts consecutive clocks of disagreement; any agreement restarts it.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
        r_cnt <= '0;
        r_f   <= 1'b0;
      end else if (r_sync2[i] == r_f) begin
        r_cnt <= '0;
      end else if (r_cnt == 8'(DEBOUNCE - 1)) begin
        r_cnt <= '0;
        r_f   <= r_sync2[i];
      end else begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
    assign w_filt[i] = r_f;
  end
`else
  assign w_filt = r_sync2;
  wire [7:0] w_unused_debounce = 8'(DEBOUNCE);
`endif

  wire w_unused_ok = &{1'b0, wb.wb_adr_i[1:0], wb.wb_dat_i, wb.wb_sel_i};

  assign wb.wb_ack_o = r_ack;
  assign wb.wb_err_o = r_err;
  assign wb.wb_dat_o = r_dat;
  assign gpio_o      = r_out;
  assign gpio_oe     = r_dir;
  assign irq         = |(r_status & r_mask);

endmodule
`default_nettype wire

// File: tb/tb_wb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_gpio_ctrl
// Purpose  : Self-checking bench for wb_gpio_ctrl. A transaction-level model
//            (register file + pin sample history) predicts pad outputs, irq
//            and read data; directed scenarios add literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_gpio_ctrl;
  localparam int W  = 8;
  localparam int DB = 4;
`ifdef WB_GPIO_CTRL_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] gpio_in;
  logic [W-1:0] gpio_o;
  logic [W-1:0] gpio_oe;
  logic         irq;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_gpio_ctrl_if bus ();

  wb_gpio_ctrl #(.WIDTH(W), .DEBOUNCE(DB)) dut (
    .wb_clk   (clk),
    .wb_rst_n (rst_n),
    .wb       (bus.slave),
    .gpio_i   (gpio_in),
    .gpio_o   (gpio_o),
    .gpio_oe  (gpio_oe),
    .irq      (irq)
  );

  // ---------------- model state ----------------
  logic [W-1:0] m_out, m_dir, m_rise, m_fall, m_status, m_mask;
  logic [W-1:0] m_fcur, m_fprev;
  logic [W-1:0] m_hist [0:7];   // m_hist[0] = pin sample taken at the previous edge
  logic         pend_we;
  logic [2:0]   pend_idx;
  logic [31:0]  pend_dat;
  logic [3:0]   pend_sel;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [W-1:0] set, clr, wm, fnext;
    if (!rst_n) begin
      m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0; m_mask = '0;
      m_fcur = '0; m_fprev = '0; pend_we = 1'b0;
      for (int j = 0; j < 8; j++) m_hist[j] = '0;
    end else begin
      set = (m_fcur & ~m_fprev & m_rise) | (~m_fcur & m_fprev & m_fall);
      clr = '0;
      if (pend_we) begin
        for (int b = 0; b < W; b++) wm[b] = pend_sel[b / 8];
        case (pend_idx)
          3'd1: m_out  = (m_out  & ~wm) | (pend_dat[W-1:0] & wm);
          3'd2: m_dir  = (m_dir  & ~wm) | (pend_dat[W-1:0] & wm);
          3'd3: m_rise = (m_rise & ~wm) | (pend_dat[W-1:0] & wm);
          3'd4: m_fall = (m_fall & ~wm) | (pend_dat[W-1:0] & wm);
          3'd5: clr    = pend_dat[W-1:0] & wm;
          3'd6: m_mask = (m_mask & ~wm) | (pend_dat[W-1:0] & wm);
          default: ;
        endcase
        pend_we = 1'b0;
      end
      m_status = (m_status & ~clr) | set;
`ifdef WB_GPIO_CTRL_DEBOUNCE_EN
      // A pin's filtered value follows once its last DB synchronized
      // samples all disagree with it.
      fnext = m_fcur;
      for (int b = 0; b < W; b++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) if (m_hist[j][b] == m_fcur[b]) all_diff = 1'b0;
        if (all_diff) fnext[b] = m_hist[0][b];
      end
`else
      fnext = m_hist[0];
`endif
      m_fprev = m_fcur;
      m_fcur  = fnext;
      for (int j = 7; j > 0; j--) m_hist[j] = m_hist[j-1];
      m_hist[0] = gpio_in;
    end
  end

  // Continuous output comparison against the model
  always @(negedge clk) begin
    check("gpio_o", 32'(gpio_o), 32'(m_out));
    check("gpio_oe", 32'(gpio_oe), 32'(m_dir));
    check("irq", 32'(irq), 32'(|(m_status & m_mask)));
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the edge following ack.
  task automatic wb_xfer(input logic we, input logic [4:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rd);
    logic [31:0] exp_rd;
    logic        bad;
    bad = (adr[4:2] == 3'd7);
    exp_rd = '0;
    case (adr[4:2])
      3'd0: exp_rd = 32'(m_fcur);
      3'd1: exp_rd = 32'(m_out);
      3'd2: exp_rd = 32'(m_dir);
      3'd3: exp_rd = 32'(m_rise);
      3'd4: exp_rd = 32'(m_fall);
      3'd5: exp_rd = 32'(m_status);
      3'd6: exp_rd = 32'(m_mask);
      default: exp_rd = '0;
    endcase
    bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel; bus.wb_we_i = we;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    if (we && !bad) begin
      pend_idx = adr[4:2]; pend_dat = dat; pend_sel = sel; pend_we = 1'b1;
    end
    @(posedge clk); #1;
    check("ack", 32'(bus.wb_ack_o), 32'(!bad));
    check("err", 32'(bus.wb_err_o), 32'(bad));
    if (!we || bad) check("dat_o", bus.wb_dat_o, exp_rd);
    rd = bus.wb_dat_o;
    @(posedge clk); #1;
    check("ack_width", 32'(bus.wb_ack_o), 32'd0);
    check("err_width", 32'(bus.wb_err_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    gpio_in = '0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
    bus.wb_we_i = 1'b0; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    tick(3);
    check("rst_gpio_o", 32'(gpio_o), 32'd0);
    check("rst_gpio_oe", 32'(gpio_oe), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Write with no byte enables changes nothing; hole address errors out
    wb_xfer(1'b1, 5'h04, 32'hFFFF_FFFF, 4'h0, rd);
    wb_xfer(1'b0, 5'h04, 32'h0, 4'hF, rd);
    check("out_sel0", rd, 32'h0);
    wb_xfer(1'b0, 5'h1C, 32'h0, 4'hF, rd);
    check("err_dat", rd, 32'h0);
    wb_xfer(1'b1, 5'h1C, 32'hFFFF_FFFF, 4'hF, rd);

    // OUT / DIR programming and readback
    wb_xfer(1'b1, 5'h04, 32'h0000_00A5, 4'hF, rd);
    wb_xfer(1'b1, 5'h08, 32'h0000_000F, 4'hF, rd);
    check("gpio_o_A5", 32'(gpio_o), 32'hA5);
    check("gpio_oe_0F", 32'(gpio_oe), 32'h0F);
    wb_xfer(1'b0, 5'h05, 32'h0, 4'hF, rd);   // low address bits ignored
    check("rd_out", rd, 32'hA5);
    wb_xfer(1'b0, 5'h08, 32'h0, 4'hF, rd);
    check("rd_dir", rd, 32'h0F);
    wb_xfer(1'b1, 5'h08, 32'hFFFF_FF33, 4'hE, rd);  // lane 0 disabled
    check("dir_lane", 32'(gpio_oe), 32'h0F);
    wb_xfer(1'b1, 5'h00, 32'hFFFF_FFFF, 4'hF, rd);  // IN is read-only
    wb_xfer(1'b0, 5'h00, 32'h0, 4'hF, rd);
    check("rd_in_0", rd, 32'h0);

    // Rising edge on pin 0 -> status/irq after the synchronizer latency
    wb_xfer(1'b1, 5'h0C, 32'h01, 4'hF, rd);
    wb_xfer(1'b1, 5'h18, 32'h01, 4'hF, rd);
    gpio_in[0] = 1'b1;
    tick(LAT - 1);
    check("irq_early", 32'(irq), 32'd0);
    tick(1);
    check("irq_set", 32'(irq), 32'd1);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, rd);
    check("status_rise", rd, 32'h01);
    wb_xfer(1'b1, 5'h14, 32'h01, 4'hF, rd);
    check("irq_w1c", 32'(irq), 32'd0);

    // Falling edge on pin 1 coinciding with a W1C of the same bit
    wb_xfer(1'b1, 5'h10, 32'h02, 4'hF, rd);
    wb_xfer(1'b1, 5'h18, 32'h03, 4'hF, rd);
    gpio_in[1] = 1'b1;
    tick(LAT + 2);
    gpio_in[1] = 1'b0;
    tick(LAT + 2);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, rd);
    check("status_fall", rd, 32'h02);
    gpio_in[1] = 1'b1;
    tick(LAT + 2);
    gpio_in[1] = 1'b0;
    tick(LAT - 1);
    wb_xfer(1'b1, 5'h14, 32'h02, 4'hF, rd);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, rd);
    check("set_beats_w1c", rd, 32'h02);
    wb_xfer(1'b1, 5'h14, 32'h02, 4'hF, rd);
    wb_xfer(1'b0, 5'h14, 32'h0, 4'hF, rd);
    check("status_clear", rd, 32'h0);

    // Multi-pin input pattern through IN
    gpio_in = 8'h3C;
    tick(LAT + 2);
    wb_xfer(1'b0, 5'h00, 32'h0, 4'hF, rd);
    check("rd_in_3C", rd, 32'h3C);
    gpio_in = 8'h00;
    tick(LAT + 2);

`ifdef WB_GPIO_CTRL_DEBOUNCE_EN
    // Short pulses are rejected, a DEBOUNCE-long level is accepted
    for (int p = 0; p < 2; p++) begin
      gpio_in[2] = 1'b1;
      tick(DB - 1);
      gpio_in[2] = 1'b0;
      tick(DB + 4);
      wb_xfer(1'b0, 5'h00, 32'h0, 4'hF, rd);
      check("deb_pulse", rd, 32'h0);
    end
    gpio_in[2] = 1'b1;
    tick(DB);
    gpio_in[2] = 1'b0;
    tick(2);
    wb_xfer(1'b0, 5'h00, 32'h0, 4'hF, rd);
    check("deb_level", rd, 32'h04);
    tick(DB + 4);
`endif

    // Reset during an outstanding read
    wb_xfer(1'b1, 5'h08, 32'hFF, 4'hF, rd);
    check("dir_ff", 32'(gpio_oe), 32'hFF);
    bus.wb_adr_i = 5'h08; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_oe_now", 32'(gpio_oe), 32'd0);
    check("rst_no_ack0", 32'(bus.wb_ack_o), 32'd0);
    @(posedge clk); #1;
    check("rst_no_ack1", 32'(bus.wb_ack_o), 32'd0);
    check("rst_no_err", 32'(bus.wb_err_o), 32'd0);
    @(posedge clk); #1;
    check("rst_no_ack2", 32'(bus.wb_ack_o), 32'd0);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    rst_n = 1'b1;
    tick(1);
    wb_xfer(1'b0, 5'h08, 32'h0, 4'hF, rd);
    check("post_rst_dir", rd, 32'h0);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/wb_gpio_ctrl.md
WB_GPIO_CTRL -- requirements
Module: wb_gpio_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning GPIO pin count, legal range 1..32.
REQ-002 SHALL have parameter DEBOUNCE, default 4, meaning consecutive stable clocks required by the filter, legal range 1..255.
REQ-003 SHALL have port wb_clk, input, 1, meaning the single clock for all logic.
REQ-004 SHALL have port wb_rst_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port wb_adr_i, input, 5, meaning byte address; bits [1:0] are ignored.
REQ-006 SHALL have ports wb_dat_i, input, 32 and wb_dat_o, output, 32, meaning write and read data.
REQ-007 SHALL have port wb_sel_i, input, 4, meaning write byte enables.
REQ-008 SHALL have ports wb_we_i, wb_cyc_i and wb_stb_i, input, 1 each, meaning standard Wishbone qualifiers.
REQ-009 SHALL have ports wb_ack_o and wb_err_o, output, 1 each, meaning transfer termination.
REQ-010 SHALL have ports gpio_i (input), gpio_o (output) and gpio_oe (output), WIDTH each, meaning pad input, pad output and output enable (1 = drive).
REQ-011 SHALL have port irq, output, 1, meaning level interrupt request.

Function
REQ-012 SHALL map registers as follows: 0x00 IN (RO), 0x04 OUT, 0x08 DIR, 0x0C RISE_EN, 0x10 FALL_EN, 0x14 STATUS (W1C), 0x18 MASK; all are WIDTH bits, LSB-aligned, with upper read bits 0.
REQ-013 SHALL terminate an access to 0x1C with wb_err_o instead of wb_ack_o; no state changes and wb_dat_o = 0.
REQ-014 SHALL assert wb_ack_o (or wb_err_o) for exactly one cycle, registered, in the cycle after wb_cyc_i & wb_stb_i is first sampled; it SHALL deassert the following cycle even if stb stays high, giving a minimum of 2 cycles per transfer.
REQ-015 SHALL apply writes at the ack edge, per byte lane, only where wb_sel_i is set; writes to IN are acked and ignored.
REQ-016 SHALL drive wb_dat_o registered and valid in the ack cycle.
REQ-017 SHALL drive gpio_o = OUT and gpio_oe = DIR directly from the registers.
REQ-018 SHALL pass gpio_i through a 2-flop synchronizer; the filtered value F feeds IN and edge detection.
REQ-019 SHALL detect edges by comparing F with a one-cycle-delayed copy; a rise on bit n with RISE_EN[n]=1, or a fall with FALL_EN[n]=1, sets STATUS[n] in the next cycle.
REQ-020 SHALL give a same-cycle set precedence over a W1C clear of the same bit.
REQ-021 SHALL drive irq = |(STATUS & MASK) combinationally from registers; STATUS bits set regardless of MASK.
REQ-022 SHALL detect edges on pins regardless of DIR (loopback allowed).

Reset
REQ-023 SHALL, on wb_rst_n low, immediately clear OUT, DIR, RISE_EN, FALL_EN, STATUS, MASK, synchronizer, filter, counters, wb_ack_o, wb_err_o and wb_dat_o; gpio_oe = 0 and irq = 0.
REQ-024 SHALL, when reset is asserted mid-transfer, abort the transfer with no ack; the first post-release access completes normally.
REQ-025 SHALL release with F = 0, so a pin held high at release produces one rise edge after synchronization (counted as a detected edge).

Configuration
REQ-026 SHALL, with macro WB_GPIO_CTRL_DEBOUNCE_EN defined, update F[n] only after the synchronized input differs from F[n] for DEBOUNCE consecutive clocks, using a per-pin counter that resets on any agreement.
REQ-027 SHALL, without WB_GPIO_CTRL_DEBOUNCE_EN, set F equal to the synchronizer output, instantiate no counters and ignore DEBOUNCE.

Verification
REQ-028 SHALL cover this scenario: write OUT=0xA5, DIR=0x0F with sel=0xF -> gpio_o=0xA5, gpio_oe=0x0F; readback matches; each ack is 1 cycle wide.
REQ-029 SHALL cover this scenario: write OUT=0xFFFFFFFF with sel=0x0 -> OUT stays 0x00; read 0x1C -> wb_err_o=1, wb_ack_o=0, dat=0.
REQ-030 SHALL cover this scenario: RISE_EN=0x01, MASK=0x01, gpio_i[0] 0->1 (no debounce) -> STATUS=0x01 and irq=1 three cycles later; W1C 0x01 -> irq=0.
REQ-031 SHALL cover this scenario: FALL_EN=0x02, with a falling edge on pin 1 in the same cycle as a W1C of 0x02 -> STATUS[1] remains 1.
REQ-032 SHALL cover this scenario: with DEBOUNCE_EN and DEBOUNCE=4, pulses of 3 clocks on pin 2 -> IN[2] stays 0; a 4-clock level -> IN[2]=1.
REQ-033 SHALL cover this scenario: assert wb_rst_n low during an outstanding read with DIR=0xFF -> gpio_oe=0 immediately, no ack; the next read completes in 2 cycles.
